spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave -- SPI mode-0 (CPOL=0, CPHA=0) slave, oversampled on clk.
//
// sclk, cs_n and mosi are asynchronous to clk. Each goes through a 2-flop
// synchronizer. sclk and cs_n then go through one more register for edge
// detection, so a pin change is acted on 3 clk later. Each sclk phase must
// last at least 4 clk.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   sclk      SPI clock from master (idle low)
//   cs_n      chip select, active low
//   mosi      master -> slave data, MSB first
//   miso      slave -> master data, MSB first (0 when not shifting)
//   tx_data   word returned to master, captured at frame start
//   rx_data   last complete word received
//   rx_valid  1-clk pulse, coincident with rx_data update
//   busy      frame in progress (SHIFT or DONE)
//   frame_err 1-clk pulse on abort or overrun (only with SPI_SLAVE_FRAME_ERR_EN)
//
// Optional feature: define SPI_SLAVE_FRAME_ERR_EN to add frame_err.
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]            sclk_sync, cs_sync, mosi_sync;
  logic                  sclk_d, cs_d;
  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next;
  logic                  smp, last_bit;

  // Synchronizers and edge registers. cs_n resets high so that reset alone
  // never looks like a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;

  // A cs_n release wins over a coincident sclk edge: the frame is aborted.
  assign smp      = (state == SHIFT) & sclk_rise & ~cs_rise;
  assign last_bit = smp & (cnt == LAST);
  assign rx_next  = {rx_shift[DATA_WIDTH-2:0], mosi_sync[1]};

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
               else if (last_bit) state_nxt = DONE;
      DONE:    if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state != IDLE);
    miso = (state == SHIFT) & tx_shift[DATA_WIDTH-1];
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // sclk edges coincident with the cs_n fall are not sampled here
          if (cs_fall) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          if (smp) begin
            rx_shift <= rx_next;
            cnt      <= cnt + CW'(1);
            if (last_bit) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end
          end
          if (sclk_fall & ~cs_rise)
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
`ifdef SPI_SLAVE_FRAME_ERR_EN
          if (cs_rise) frame_err <= 1'b1;
`endif
        end
        DONE: begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
          // extra clock edges past the last bit
          if (sclk_rise) frame_err <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
